// File: rtl/msu_data_fetch.sv
`default_nettype none
// msu_data_fetch: MSU data-track prefetch FIFO with a single-outstanding byte fetch port.
// Rev 1.0
module msu_data_fetch #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_seek,
  input  logic [31:0] i_seek_addr,
  input  logic        i_rd_adv,
  output logic [7:0]  o_data_out,
  output logic        o_busy,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_data,
  output logic        o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ALMOST  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_READY = 2'd3;

  logic [1:0]    r_state, w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_faddr, r_mem_addr;
  logic          r_mem_req, r_underflow;
  logic          w_ack, w_active, w_wr, w_rd, w_underrun;

  // An acknowledge only counts against a live request; strays are dropped.
  assign w_ack      = i_mem_ack & r_mem_req;
  assign w_active   = (r_state == S_FILL) || (r_state == S_READY);
  assign w_wr       = w_active & w_ack & ~i_seek;
  assign w_rd       = (r_state == S_READY) & i_rd_adv & ~i_seek & (r_count != '0);
  assign w_underrun = (r_state == S_READY) & i_rd_adv & ~i_seek & (r_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_seek) begin
      w_state_nxt = (r_mem_req && !i_mem_ack) ? S_DRAIN : S_FILL;
    end else begin
      case (r_state)
        S_DRAIN: if (w_ack) w_state_nxt = S_FILL;
        S_FILL:  if (w_wr && (r_count == C_ALMOST)) w_state_nxt = S_READY;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_faddr     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_underflow <= 1'b0;
    end else if (i_seek) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_faddr     <= i_seek_addr;
      r_underflow <= 1'b0;
      // An unacknowledged request keeps its address and is drained later.
      r_mem_req   <= r_mem_req & ~i_mem_ack;
    end else begin
      if (r_state == S_DRAIN) begin
        if (w_ack) r_mem_req <= 1'b0;
      end else if (w_active) begin
        if (w_wr) begin
          r_mem_req <= 1'b0;
          r_wr_ptr  <= r_wr_ptr + C_PTR_ONE;
          r_faddr   <= r_faddr + 32'd1;
        end else if (!r_mem_req && (r_count < C_FULL)) begin
          r_mem_req  <= 1'b1;
          r_mem_addr <= r_faddr;
        end
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      if (w_wr && !w_rd)      r_count <= r_count + C_CNT_ONE;
      else if (!w_wr && w_rd) r_count <= r_count - C_CNT_ONE;
      if (w_underrun) r_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_mem_data;
  end

  always_comb begin
    o_busy     = (r_state == S_DRAIN) || (r_state == S_FILL);
    o_data_out = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_underflow = r_underflow;

endmodule
`default_nettype wire
